// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and constants for the SPI bus arbiter: FSM state encoding,
// byte width and small elaboration-time helpers.
package spi_bus_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_XFER   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of an index into n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_picker.sv
// Round-robin priority picker: first asserted request at or after the
// pointer, wrapping, reported as one-hot grant plus its index.
module rr_priority_picker
  import spi_bus_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  logic found;

  // NOTE: every output gets a default before the search loop, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    any_o   = |req_i;
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (int'(ptr_i) + off) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        idx_o        = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI byte engine between NUM_REQUESTERS masters: round-robin
// grant per burst, per-requester active-low CS with setup and hold timing.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS  = 2,
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2
) (
  input  logic                             clock_i,
  input  logic                             reset_ni,
  input  logic [NUM_REQUESTERS-1:0]        req_i,
  input  logic [NUM_REQUESTERS-1:0]        req_valid_i,
  input  logic [DATA_W*NUM_REQUESTERS-1:0] req_wdata_i,
  output logic [NUM_REQUESTERS-1:0]        req_ready_o,
  output logic [NUM_REQUESTERS-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]                rsp_rdata_o,
  output logic [NUM_REQUESTERS-1:0]        grant_o,
  output logic                             engine_start_o,
  output logic [DATA_W-1:0]                engine_wdata_o,
  input  logic                             engine_busy_i,
  input  logic                             engine_done_i,
  input  logic [DATA_W-1:0]                engine_rdata_i,
  output logic [NUM_REQUESTERS-1:0]        cs_o
);

  localparam int N     = NUM_REQUESTERS;
  localparam int PTR_W = idx_width(N);
  localparam int CNT_W = $clog2(max2(CS_SETUP_CYCLES, CS_HOLD_CYCLES) + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(N - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   own_q;
  logic [N-1:0]       grant_q;
  logic [N-1:0]       cs_q;
  logic [N-1:0]       req_ready_q;
  logic [N-1:0]       rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               engine_start_q;
  logic [DATA_W-1:0]  engine_wdata_q;

  logic [N-1:0]       pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               own_req;
  logic               own_valid;
  logic [DATA_W-1:0]  own_wdata;
  logic [PTR_W-1:0]   ptr_d;

  rr_priority_picker #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign own_req   = req_i[own_q];
  assign own_valid = req_valid_i[own_q];
  assign own_wdata = req_wdata_i[own_q*DATA_W +: DATA_W];
  assign ptr_d     = (own_q == LAST_IDX) ? '0 : own_q + PTR_W'(1);

  // NOTE: all state here uses non-blocking assignments; the pulse defaults at
  // the top are overridden by later assignments in the same clock.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      ptr_q          <= '0;
      own_q          <= '0;
      grant_q        <= '0;
      cs_q           <= '1;
      req_ready_q    <= '0;
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
      engine_start_q <= 1'b0;
      engine_wdata_q <= '0;
    end else begin
      req_ready_q    <= '0;
      rsp_valid_q    <= '0;
      engine_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_grant;
            cs_q    <= ~pick_grant;
            own_q   <= pick_idx;
            cnt_q   <= SETUP_LOAD;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) state_q <= ST_ACTIVE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        ST_ACTIVE: begin
          // A pending byte wins over a dropped request in the same cycle.
          if (own_valid && !engine_busy_i) begin
            req_ready_q[own_q] <= 1'b1;
            engine_start_q     <= 1'b1;
            engine_wdata_q     <= own_wdata;
            state_q            <= ST_XFER;
          end else if (!own_req) begin
            cnt_q   <= HOLD_LOAD;
            state_q <= ST_HOLD;
          end
        end
        ST_XFER: begin
          if (engine_done_i) begin
            rsp_rdata_q        <= engine_rdata_i;
            rsp_valid_q[own_q] <= 1'b1;
            state_q            <= ST_ACTIVE;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            cs_q    <= '1;
            grant_q <= '0;
            ptr_q   <= ptr_d;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign grant_o        = grant_q;
  assign cs_o           = cs_q;
  assign engine_start_o = engine_start_q;
  assign engine_wdata_o = engine_wdata_q;

endmodule
